// File: rtl/dr_tx_rtz.sv
// Clocked-to-dual-rail transmitter: sends each accepted word as one dual-rail DATA wavefront,
// followed by a NULL spacer, using a 4-phase return-to-zero handshake on an asynchronous ack.
//
// state | meaning
// IDLE  | NULL on the rails, accepting a word when ack_s is low
// DATA  | codeword held on the rails until ack_s rises
// NULLW | NULL on the rails, waiting for ack_s to fall
// SPACE | NULL held for NULL_HOLD cycles before returning to IDLE
module dr_tx_rtz #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int NULL_HOLD   = 1,
  parameter int TIMEOUT     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  input  logic             ack_in,
  output logic             busy,
  output logic             err_timeout,
  input  logic             err_clr
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int HW = (NULL_HOLD > 1) ? $clog2(NULL_HOLD) : 1;

  typedef enum logic [1:0] {IDLE, DATA, NULLW, SPACE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic [TW-1:0]          tcnt;
  logic [HW-1:0]          hcnt;
  logic                   ack_s;
  logic                   waiting;
  logic                   to_hit;
  logic                   ready_nxt;

  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign waiting = ((state == DATA) && !ack_s) || ((state == NULLW) && ack_s);
  assign to_hit  = (TIMEOUT > 0) && waiting && (tcnt == TW'(TIMEOUT - 1));

  // fill_q marks synchronizer stages that hold a real sample since reset, so a
  // stale ack that was high across reset cannot open in_ready before it is seen.
  assign ready_nxt = fill_q[SYNC_STAGES-2] && !sync_q[SYNC_STAGES-2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sync_q      <= '0;
      fill_q      <= '0;
      d0          <= '0;
      d1          <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      tcnt        <= '0;
      hcnt        <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], ack_in};
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      in_ready <= 1'b0;

      if (to_hit)
        err_timeout <= 1'b1;
      else if (err_clr)
        err_timeout <= 1'b0;

      if (waiting && (tcnt != TW'(TIMEOUT)))
        tcnt <= tcnt + TW'(1);

      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            d1    <= in_data;
            d0    <= ~in_data;
            busy  <= 1'b1;
            tcnt  <= '0;
            state <= DATA;
          end else begin
            in_ready <= ready_nxt;
          end
        end
        DATA: begin
          if (ack_s) begin
            d0    <= '0;
            d1    <= '0;
            tcnt  <= '0;
            state <= NULLW;
          end
        end
        NULLW: begin
          if (!ack_s) begin
            hcnt  <= HW'(NULL_HOLD - 1);
            state <= SPACE;
          end
        end
        SPACE: begin
          if (hcnt == '0) begin
            busy     <= 1'b0;
            in_ready <= ready_nxt;
            state    <= IDLE;
          end else begin
            hcnt <= hcnt - HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dr_tx_rtz.sv
// Self-checking bench for dr_tx_rtz: directed handshake/timeout/reset scenarios plus a
// randomized stream scored against a word queue and a behavioural receiver.
module tb_dr_tx_rtz;
  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int HOLD  = 1;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             ack_in;
  logic             busy;
  logic             err_timeout;
  logic             err_clr;

  int checks = 0;
  int passed = 0;
  bit stuck  = 1'b0;

  logic [WIDTH-1:0] txq[$];
  logic [WIDTH-1:0] expq[$];

  int   rail_viol = 0;
  int   partial   = 0;
  int   wf_count  = 0;
  logic prev_full = 1'b0;

  dr_tx_rtz #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .NULL_HOLD(HOLD), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .d0(d0), .d1(d1), .ack_in(ack_in), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Rail monitor: illegal rail pairs, half-formed wavefronts, and count of DATA wavefronts.
  always @(negedge clk) begin
    if (|(d0 & d1)) rail_viol++;
    if ((|(d0 | d1)) && !(&(d0 | d1))) partial++;
    if ((&(d0 | d1)) && !prev_full) wf_count++;
    prev_full = &(d0 | d1);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, checks);
    $fatal(1);
  end

  task automatic settle();
    int t;
    t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (!in_ready) begin
      $display("FAIL settle: in_ready=%b required 1 within 200 cycles", in_ready);
      stuck = 1'b1;
    end else passed++;
  endtask

  task automatic tx_stream(input bit gaps);
    int t;
    while (txq.size() > 0 && !stuck) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        @(negedge clk);
        continue;
      end
      in_valid = 1'b1;
      in_data  = txq[0];
      t = 0;
      while (!in_ready && t < 300 && !stuck) begin @(negedge clk); t++; end
      if (!in_ready) begin
        checks++;
        $display("FAIL tx_accept: in_ready=%b required 1 within 300 cycles", in_ready);
        stuck = 1'b1;
        break;
      end
      expq.push_back(in_data);
      void'(txq.pop_front());
      @(negedge clk);
      in_data = WIDTH'($urandom);
    end
    in_valid = 1'b0;
  endtask

  // Receiver model: completion on a full wavefront, ack after a delay, release after NULL.
  task automatic rx_stream(input int n, input int maxd);
    int t, dly;
    bit hold_ok;
    logic [WIDTH-1:0] got, exp_w;
    for (int w = 0; w < n && !stuck; w++) begin
      t = 0;
      while (!(&(d0 | d1)) && t < 300 && !stuck) begin @(negedge clk); t++; end
      if (!(&(d0 | d1))) begin
        checks++;
        $display("FAIL rx_wait_data: d0|d1=%h required all ones within 300 cycles", d0 | d1);
        stuck = 1'b1;
        break;
      end
      got = d1;
      checks++;
      if (expq.size() == 0) begin
        $display("FAIL rx_word: received d1=%h but no word was accepted", got);
      end else begin
        exp_w = expq.pop_front();
        if (d1 !== exp_w || d0 !== ~exp_w)
          $display("FAIL rx_word: d1=%h d0=%h required d1=%h d0=%h", d1, d0, exp_w, ~exp_w);
        else passed++;
      end
      dly = $urandom_range(1, maxd);
      hold_ok = 1'b1;
      repeat (dly) begin
        @(negedge clk);
        if (d1 !== got || d0 !== ~got) hold_ok = 1'b0;
      end
      checks++;
      if (!hold_ok) $display("FAIL rx_hold: d1=%h required held %h until ack", d1, got);
      else passed++;
      ack_in = 1'b1;
      t = 0;
      while ((|(d0 | d1)) && t < 300) begin @(negedge clk); t++; end
      if (|(d0 | d1)) begin
        checks++;
        $display("FAIL rx_wait_null: d0|d1=%h required 0 within 300 cycles", d0 | d1);
        stuck = 1'b1;
        break;
      end
      dly = $urandom_range(1, maxd);
      repeat (dly) @(negedge clk);
      ack_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (d0 !== '0) $display("FAIL reset_d0: d0=%h required 00", d0); else passed++;
    checks++; if (d1 !== '0) $display("FAIL reset_d1: d1=%h required 00", d1); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_ready: in_ready=%b required 0", in_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: busy=%b required 0", busy); else passed++;
    checks++; if (err_timeout !== 1'b0) $display("FAIL reset_err: err_timeout=%b required 0", err_timeout); else passed++;
    reset = 1'b0;
    settle();
  endtask

  task automatic test_handshake();
    int n;
    bit ready_low;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    checks++; if (d1 !== 8'hA5) $display("FAIL hs_d1: d1=%h required a5", d1); else passed++;
    checks++; if (d0 !== 8'h5A) $display("FAIL hs_d0: d0=%h required 5a", d0); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL hs_busy: busy=%b required 1", busy); else passed++;
    repeat (2) @(negedge clk);
    ack_in = 1'b1;
    n = 0;
    ready_low = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (in_ready) ready_low = 1'b0;
    end while ((|(d0 | d1)) && n < 20);
    checks++;
    if (n != SYNC + 1) $display("FAIL hs_null_latency: NULL after %0d edges, required %0d", n, SYNC + 1);
    else passed++;
    ack_in = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (in_ready && n < SYNC + HOLD + 1) ready_low = 1'b0;
    end while (!in_ready && n < 20);
    checks++;
    if (!ready_low) $display("FAIL hs_ready_low: in_ready rose before the cycle sequence completed");
    else passed++;
    // ack_s drops after SYNC edges, one edge leaves NULLW, HOLD edges in SPACE.
    checks++;
    if (n != SYNC + HOLD + 1) $display("FAIL hs_ready_latency: in_ready after %0d edges, required %0d", n, SYNC + HOLD + 1);
    else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL hs_busy_end: busy=%b required 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    int wf0, rv0, pt0;
    settle();
    wf0 = wf_count; rv0 = rail_viol; pt0 = partial;
    txq = '{8'h00, 8'hFF, 8'h3C};
    expq.delete();
    fork
      tx_stream(1'b0);
      rx_stream(3, 1);
    join
    checks++;
    if (wf_count - wf0 != 3) $display("FAIL b2b_wavefronts: %0d wavefronts, required 3", wf_count - wf0);
    else passed++;
    checks++;
    if (rail_viol != rv0) $display("FAIL b2b_rails: %0d cycles with d0&d1, required 0", rail_viol - rv0);
    else passed++;
    checks++;
    if (partial != pt0) $display("FAIL b2b_partial: %0d half-formed cycles, required 0", partial - pt0);
    else passed++;
  endtask

  task automatic finish_word();
    int t;
    ack_in = 1'b1;
    t = 0;
    while ((|(d0 | d1)) && t < 50) begin @(negedge clk); t++; end
    ack_in = 1'b0;
    settle();
  endtask

  task automatic test_timeout();
    logic [WIDTH-1:0] w;
    settle();
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    w = WIDTH'($urandom);
    in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0; in_data = ~w;
    // err_timeout rises on the TMO-th edge after entry to DATA.
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      if (i == TMO - 1) begin
        checks++;
        if (err_timeout !== 1'b0) $display("FAIL to_early: err_timeout=%b required 0 at edge %0d", err_timeout, i);
        else passed++;
      end
    end
    checks++; if (err_timeout !== 1'b1) $display("FAIL to_set: err_timeout=%b required 1", err_timeout); else passed++;
    checks++; if (d1 !== w || d0 !== ~w) $display("FAIL to_hold: d1=%h required %h", d1, w); else passed++;
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b0) $display("FAIL to_clear: err_timeout=%b required 0", err_timeout); else passed++;
    checks++; if (d1 !== w) $display("FAIL to_hold_after_clr: d1=%h required %h", d1, w); else passed++;
    finish_word();
    w = WIDTH'($urandom);
    in_valid = 1'b1; in_data = w;
    @(negedge clk);
    in_valid = 1'b0;
    err_clr  = 1'b1;
    repeat (TMO) @(negedge clk);
    checks++; if (err_timeout !== 1'b1) $display("FAIL to_set_wins: err_timeout=%b required 1", err_timeout); else passed++;
    @(negedge clk);
    checks++; if (err_timeout !== 1'b0) $display("FAIL to_clr_after: err_timeout=%b required 0", err_timeout); else passed++;
    err_clr = 1'b0;
    finish_word();
  endtask

  task automatic test_reset_mid();
    int n;
    bit stale_ok;
    settle();
    in_valid = 1'b1; in_data = 8'h96;
    @(negedge clk);
    in_valid = 1'b0;
    ack_in   = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (d0 !== '0 || d1 !== '0) $display("FAIL rm_null: d0=%h d1=%h required 00 00", d0, d1); else passed++;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL rm_flags: busy=%b in_ready=%b required 0 0", busy, in_ready); else passed++;
    reset = 1'b0;
    stale_ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (in_ready || (|(d0 | d1))) stale_ok = 1'b0;
    end
    checks++; if (!stale_ok) $display("FAIL rm_stale_ack: in_ready or data rose while ack_in=1"); else passed++;
    ack_in = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 20);
    checks++;
    if (!in_ready || n > SYNC + 1) $display("FAIL rm_release: in_ready=%b after %0d edges, required 1 within %0d", in_ready, n, SYNC + 1);
    else passed++;
  endtask

  task automatic test_random();
    int rv0, pt0;
    settle();
    rv0 = rail_viol; pt0 = partial;
    expq.delete();
    for (int i = 0; i < 1000; i++) txq.push_back(WIDTH'($urandom));
    fork
      tx_stream(1'b1);
      rx_stream(1000, 20);
    join
    checks++; if (expq.size() != 0) $display("FAIL rnd_leftover: %0d words not received, required 0", expq.size()); else passed++;
    checks++; if (rail_viol != rv0) $display("FAIL rnd_rails: %0d cycles with d0&d1, required 0", rail_viol - rv0); else passed++;
    checks++; if (partial != pt0) $display("FAIL rnd_partial: %0d half-formed cycles, required 0", partial - pt0); else passed++;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; ack_in = 1'b0; err_clr = 1'b0;
    test_reset();
    test_handshake();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
